fifo_hs_8b_8d: RTL and testbench



---
 rtl/fifo_hs_8b_8d_pkg.sv | 17 +
 rtl/fifo_hs_8b_8d_if.sv | 33 +++
 rtl/fifo_hs_8b_8d_ptr.sv | 35 +++
 rtl/fifo_hs_8b_8d.sv | 126 ++++++++++++
 tb/tb_fifo_hs_8b_8d.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/fifo_hs_8b_8d_pkg.sv
// Shared constants and types for the 8-bit x 8-entry handshaked FIFO.
package fifo_pkg;

    // Default geometry of the buffer.
    localparam int FIFO_WIDTH = 8;
    localparam int FIFO_DEPTH = 8;

    // Pointer width addresses DEPTH entries; the counter needs one more bit
    // so that it can hold DEPTH itself (the full condition).
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef logic [FIFO_WIDTH-1:0] data_t;
    typedef logic [PTR_W-1:0]      ptr_t;
    typedef logic [CNT_W-1:0]      cnt_t;

endpackage : fifo_pkg

// File: rtl/fifo_hs_8b_8d_if.sv
// Producer/consumer handshake bundle of the FIFO.
// The FIFO itself uses the slave modport; the environment uses master.
interface fifo_hs_8b_8d_if #(
    parameter int WIDTH = fifo_pkg::FIFO_WIDTH,
    parameter int DEPTH = fifo_pkg::FIFO_DEPTH
);

    // Write side
    logic [WIDTH-1:0]         din;
    logic                     in_valid;
    logic                     in_ready;

    // Read side (first-word-fall-through)
    logic [WIDTH-1:0]         dout;
    logic                     out_valid;
    logic                     out_ready;

    // Status
    logic [$clog2(DEPTH):0]   count;
    logic                     ovf;
    logic                     udf;

    modport slave (
        input  din, in_valid, out_ready,
        output in_ready, dout, out_valid, count, ovf, udf
    );

    modport master (
        output din, in_valid, out_ready,
        input  in_ready, dout, out_valid, count, ovf, udf
    );

endinterface : fifo_hs_8b_8d_if

// File: rtl/fifo_hs_8b_8d_ptr.sv
// Wrap-around pointer register: advances by one when enabled, wraps
// naturally at 2**W, and clears on synchronous active-high reset.
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int W = PTR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    output logic [W-1:0] ptr_o
);

    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;

    // Next pointer value: increment modulo 2**W when enabled.
    always_comb begin
        ptr_d = en_i ? ptr_q + W'(1) : ptr_q;
    end

    // Pointer state with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking (<=) in clocked blocks so every register samples
        // the pre-edge values; blocking here would create ordering races.
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule : fifo_ptr

// File: rtl/fifo_hs_8b_8d.sv
// Handshaked FIFO, 8 bits x 8 entries, circular register array.
// Full/empty are decoded from a registered occupancy counter; dout is the
// head entry read combinationally from the array (first-word-fall-through).
module fifo_hs_8b_8d
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    fifo_hs_8b_8d_if.slave   hs
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Storage and pointers
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;

    // Occupancy and error pulses
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             udf_q;
    logic             udf_d;

    // Handshake decode
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

    // A write is only accepted when not full and a read only when not
    // empty, so at the boundaries a simultaneous request degrades to a
    // single operation and the rejected side raises ovf/udf.
    assign push  = hs.in_valid  && !full;
    assign pop   = hs.out_ready && !empty;

    // Next occupancy and error-pulse values.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        count_d = count_q;
        ovf_d   = 1'b0;
        udf_d   = 1'b0;

        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        ovf_d = hs.in_valid  && full;
        udf_d = hs.out_ready && empty;
    end

    // Read and write pointers.
    fifo_ptr #(.W(AW)) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .en_i  (push),
        .ptr_o (wr_ptr)
    );

    fifo_ptr #(.W(AW)) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .en_i  (pop),
        .ptr_o (rd_ptr)
    );

    // Data array write; a push coinciding with reset is discarded.
    always_ff @(posedge clk) begin
        // NOTE: the array is deliberately not reset. Entries are only ever
        // read after being written, and leaving the reset out keeps it a
        // plain register file / RAM.
        if (push && !rst) begin
            mem_q[wr_ptr] <= hs.din;
        end
    end

    // Occupancy counter and registered error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Outputs
    assign hs.in_ready  = !full;
    assign hs.out_valid = !empty;
    assign hs.dout      = mem_q[rd_ptr];
    assign hs.count     = count_q;
    assign hs.ovf       = ovf_q;
    assign hs.udf       = udf_q;

    // Occupancy can never exceed the depth.
    a_count_range: assert property (
        @(posedge clk) disable iff (rst) count_q <= FULL_CNT
    );

    // A rejected write always raises ovf on the following cycle.
    a_ovf_pulse: assert property (
        @(posedge clk) disable iff (rst) (hs.in_valid && full) |=> ovf_q
    );

    // A rejected read always raises udf on the following cycle.
    a_udf_pulse: assert property (
        @(posedge clk) disable iff (rst) (hs.out_ready && empty) |=> udf_q
    );

endmodule : fifo_hs_8b_8d

// File: tb/tb_fifo_hs_8b_8d.sv
// Directed bench for fifo_hs_8b_8d: a vector table for reset/fill/drain,
// plus hand-written sequences for streaming, boundary and reset corners.
module tb_fifo_hs_8b_8d;
    import fifo_pkg::*;

    typedef struct {
        logic       rst;
        logic       in_valid;
        logic [7:0] din;
        logic       out_ready;
        logic [3:0] exp_count;
        logic       exp_ovf;
        logic       exp_udf;
        logic       chk_dout;
        logic [7:0] exp_dout;
    } vec_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;
    vec_t vecs[$];

    fifo_hs_8b_8d_if hs_if ();

    fifo_hs_8b_8d dut (
        .clk (clk),
        .rst (rst),
        .hs  (hs_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic iv, input logic [7:0] d, input logic ordy,
                       input logic [3:0] cnt, input logic ovf, input logic udf,
                       input logic chk, input logic [7:0] dq);
        vec_t v;
        v.rst = r; v.in_valid = iv; v.din = d; v.out_ready = ordy;
        v.exp_count = cnt; v.exp_ovf = ovf; v.exp_udf = udf;
        v.chk_dout = chk; v.exp_dout = dq;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs, let one rising edge pass, sample 1 ns later.
    task automatic cycle(input logic r, input logic iv, input logic [7:0] d, input logic ordy);
        rst             = r;
        hs_if.in_valid  = iv;
        hs_if.din       = d;
        hs_if.out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    // Compare all observable state against expectations; status flags are
    // derived from the expected count here, independently of the DUT.
    task automatic expect_state(input string tag, input logic [3:0] cnt, input logic ovf,
                                input logic udf, input logic chk, input logic [7:0] dq);
        check({tag, " count"},     32'(hs_if.count),     32'(cnt));
        check({tag, " out_valid"}, 32'(hs_if.out_valid), 32'(cnt != 0));
        check({tag, " in_ready"},  32'(hs_if.in_ready),  32'(cnt != 4'd8));
        check({tag, " ovf"},       32'(hs_if.ovf),       32'(ovf));
        check({tag, " udf"},       32'(hs_if.udf),       32'(udf));
        if (chk) check({tag, " dout"}, 32'(hs_if.dout), 32'(dq));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst             = 1'b1;
        hs_if.in_valid  = 1'b0;
        hs_if.din       = 8'h00;
        hs_if.out_ready = 1'b0;

        // ---- Table: reset with in_valid high, fill, overflow, drain, underflow
        add(1, 1, 8'h55, 0, 4'd0, 0, 0, 0, 8'h00);
        add(1, 1, 8'h55, 0, 4'd0, 0, 0, 0, 8'h00);
        add(0, 0, 8'h00, 0, 4'd0, 0, 0, 0, 8'h00);
        for (int k = 1; k <= 8; k++)
            add(0, 1, 8'(k), 0, 4'(k), 0, 0, 1, 8'h01);
        add(0, 1, 8'h09, 0, 4'd8, 1, 0, 1, 8'h01);   // 9th push rejected
        add(0, 0, 8'h00, 0, 4'd8, 0, 0, 1, 8'h01);   // ovf lasts one cycle
        for (int k = 1; k <= 7; k++)
            add(0, 0, 8'h00, 1, 4'(8 - k), 0, 0, 1, 8'(k + 1));
        add(0, 0, 8'h00, 1, 4'd0, 0, 0, 0, 8'h00);   // last pop
        add(0, 0, 8'h00, 1, 4'd0, 0, 1, 0, 8'h00);   // read while empty
        add(0, 0, 8'h00, 0, 4'd0, 0, 0, 0, 8'h00);   // udf lasts one cycle

        foreach (vecs[i]) begin
            cycle(vecs[i].rst, vecs[i].in_valid, vecs[i].din, vecs[i].out_ready);
            expect_state($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_ovf,
                         vecs[i].exp_udf, vecs[i].chk_dout, vecs[i].exp_dout);
        end

        // ---- Streaming 0x10..0x2F with out_ready held high (4 pointer wraps)
        for (int k = 0; k < 32; k++) begin
            cycle(0, 1, 8'(8'h10 + k), 1);
            expect_state($sformatf("stream%0d", k), 4'd1, 1'b0, k == 0, 1'b1, 8'(8'h10 + k));
        end
        cycle(0, 0, 8'h00, 1);
        expect_state("stream_end", 4'd0, 0, 0, 0, 8'h00);

        // ---- Full with push and pop together: only the pop happens
        for (int k = 0; k < 8; k++) cycle(0, 1, 8'(8'h30 + k), 0);
        expect_state("bnd_full", 4'd8, 0, 0, 1, 8'h30);
        cycle(0, 1, 8'h99, 1);
        expect_state("bnd_full_both", 4'd7, 1, 0, 1, 8'h31);
        for (int k = 1; k < 7; k++) begin
            cycle(0, 0, 8'h00, 1);
            expect_state($sformatf("bnd_drain%0d", k), 4'(7 - k), 0, 0, 1, 8'(8'h31 + k));
        end
        cycle(0, 0, 8'h00, 1);
        expect_state("bnd_drained", 4'd0, 0, 0, 0, 8'h00);

        // ---- Empty with push and pop together: only the push happens
        cycle(0, 1, 8'h77, 1);
        expect_state("bnd_empty_both", 4'd1, 0, 1, 1, 8'h77);
        cycle(0, 0, 8'h00, 1);
        expect_state("bnd_empty_pop", 4'd0, 0, 0, 0, 8'h00);

        // ---- Reset mid-operation with a concurrent push/pop
        for (int k = 0; k < 5; k++) cycle(0, 1, 8'(8'h40 + k), 0);
        expect_state("mid_loaded", 4'd5, 0, 0, 1, 8'h40);
        cycle(1, 1, 8'hEE, 1);
        expect_state("mid_reset", 4'd0, 0, 0, 0, 8'h00);
        cycle(0, 1, 8'hA5, 0);
        expect_state("mid_push", 4'd1, 0, 0, 1, 8'hA5);
        cycle(0, 0, 8'h00, 1);
        expect_state("mid_pop", 4'd0, 0, 0, 0, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_fifo_hs_8b_8d
